data_mem_unit: RTL and testbench
================================

// Module: data_mem_unit
// PURPOSE
//  Byte-addressed, word-organised data/instruction memory directly downstream of the
//  multicycle MIPS core. Consumes MemWrite/MemMode/memAddr/writeMemData and returns
//  registered read data (memData).
//  Handles word, halfword and byte lanes in big-endian order and flags misaligned accesses.
//  Also provides a host program-load port: after reset it holds the core and fills RAM
//  before releasing the core into RUN.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; word index = memAddr[15:2]
// PORTS
//  clk           in   1   single clock, rising edge
//  reset         in   1   asynchronous, active-low; all state below is cleared while low
//  MemWrite      in   1   core write strobe, sampled at rising clk
//  MemMode       in   2   00 word, 01 halfword, 10 byte, 11 reserved
//  memAddr       in   16  byte address from core
//  writeMemData  in   32  store data, right-justified (byte in [7:0], half in [15:0])
//  memData       out  32  registered read data to core, right-justified, zero-extended
//  load_valid    in   1   host word available
//  load_data     in   32  host word
//  load_last     in   1   qualifies final host word
//  load_ready    out  1   unit accepts host word this cycle
//  cpu_hold      out  1   1 = core must stay halted (unit still loading)
//  misalign_err  out  1   sticky access-error flag
// BEHAVIOUR
//  Reset (reset=0)
//   - state=LOAD, load pointer=0, memData=0, misalign_err=0, load_ready=0, cpu_hold=1.
//   - RAM contents are NOT cleared.
//  LOAD state
//   - load_ready=1, cpu_hold=1, memData held at 0.
//   - Core inputs are ignored; MemWrite has no effect.
//   - Handshake: a word is accepted on a clk edge with load_valid & load_ready.
//     RAM[ptr] <= load_data, then ptr <= ptr+1.
//   - Transition to RUN on acceptance when load_last=1, or when ptr==DEPTH_WORDS-1
//     (pointer never wraps).
//   - Loading stops after the transfer that causes this transition; it is the final one.
//  RUN state
//   - load_ready=0 and cpu_hold=0.
//   - RUN is left only by reset. Reset during LOAD restarts at ptr=0.
//  Read (RUN, every cycle)
//   - memData updates at every rising edge; latency = 1 cycle.
//   - Read-before-write: a write at the same edge returns the OLD word's lane.
//   - Lane selection, big-endian:
//     - Word: memData = RAM[w].
//     - Half: addr[1]=0 -> [31:16], addr[1]=1 -> [15:0].
//     - Byte: addr[1:0]=00 -> [31:24], 01 -> [23:16], 10 -> [15:8], 11 -> [7:0].
//   - Result is zero-extended to 32 bits.
//  Write (RUN, MemWrite=1)
//   - Only the selected lane(s) are written; other bytes are preserved.
//   - Lane data comes from writeMemData low bits.
//  Errors
//   - Misaligned access (treated as an error):
//     - word with addr[1:0]!=0
//     - half with addr[0]=1
//     - MemMode=11
//   - Out of range (word index >= DEPTH_WORDS):
//     - also sets misalign_err
//     - reads return 0, writes are dropped
//   - On a misaligned access: no RAM write, memData <= 0, misalign_err <= 1.
//   - misalign_err is sticky until reset.
//   - Errors are evaluated only in RUN. In RUN they are evaluated every cycle, read or
//     write, because memAddr is always presented.
// TESTING
//  1. Load handshake:
//     - stimulus: load 3 words 0x11111111, 0x22222222, 0x33333333 with load_last on the
//       3rd, load_valid toggled with gaps
//     - required: exactly 3 transfers; cpu_hold falls the cycle after the 3rd;
//       RAM[0..2] match
//  2. Word R/W:
//     - stimulus: RUN, write 0xDEADBEEF @0x0010, then read @0x0010
//     - required: memData=0xDEADBEEF one cycle after the read address is applied
//  3. Byte/half lanes:
//     - stimulus: word 0xDEADBEEF @0x10, then byte write 0xAA @0x0011,
//       then half read @0x0010 and byte read @0x0013
//     - required: 0x0000DEAA and 0x000000EF; word read gives 0xDEAABEEF
//  4. Misalign:
//     - stimulus: word write @0x0012 of 0x12345678
//     - required: RAM unchanged, memData=0, misalign_err=1 and stays 1 until reset
//  5. Read-before-write:
//     - stimulus: same-cycle read/write @0x20, old=0x1, new=0x2
//     - required: memData=0x1 that cycle; next read gives 0x2
//  6. Reset mid-load:
//     - stimulus: reset low after 2 of 4 words, then reload 1 word with load_last
//     - required: ptr restarts at 0; RAM[0]=new word, RAM[1] retains old value;
//       misalign_err=0 throughout

Source files
------------

// File: rtl/data_mem_unit.sv
// data_mem_unit: byte-addressed big-endian word RAM behind the multicycle MIPS core, with host program-load
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset (RAM contents survive)
//   MemWrite     in   core store strobe
//   MemMode      in   00 word, 01 halfword, 10 byte, 11 reserved
//   memAddr      in   byte address, word index = memAddr[15:2]
//   writeMemData in   store data, right-justified
//   memData      out  registered, zero-extended read data
//   load_valid   in   host word available
//   load_data    in   host word
//   load_last    in   marks final host word
//   load_ready   out  host word accepted this cycle when valid
//   cpu_hold     out  core halted while loading
//   misalign_err out  sticky access-error flag
module data_mem_unit #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [1:0]  MemMode,
    input  logic [15:0] memAddr,
    input  logic [31:0] writeMemData,
    output logic [31:0] memData,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        cpu_hold,
    output logic        misalign_err
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic {LOAD, RUN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [31:0]     mem_data_q, mem_data_d;
    logic            ready_q, ready_d;
    logic            err_q, err_d;
    logic [31:0]     ram [DEPTH_WORDS];
    logic [13:0]     idx;
    logic            oob, bad;
    logic [31:0]     rd_word, lane_sh, lane, wlane, ram_wdata;
    logic [4:0]      shamt;
    logic [3:0]      be, ram_we;
    logic [AW-1:0]   ram_addr;

    assign idx = memAddr[15:2];
    assign oob = {18'd0, idx} >= 32'(DEPTH_WORDS);
    assign bad = oob || MemMode == 2'b11 || (MemMode == 2'b00 && memAddr[1:0] != 2'b00)
                     || (MemMode == 2'b01 && memAddr[0]);
    // Out-of-range indices alias here, but bad masks both the read and the write.
    assign rd_word = ram[idx[AW-1:0]];
    // Big-endian: lane 0 of a word is its most significant byte, so shift right by the inverted offset.
    assign shamt   = MemMode == 2'b01 ? {~memAddr[1], 4'b0000} : {~memAddr[1:0], 3'b000};
    assign lane_sh = rd_word >> shamt;
    assign lane    = MemMode == 2'b00 ? rd_word :
                     MemMode == 2'b01 ? {16'd0, lane_sh[15:0]} : {24'd0, lane_sh[7:0]};
    assign be      = MemMode == 2'b00 ? 4'hF :
                     MemMode == 2'b01 ? (memAddr[1] ? 4'b0011 : 4'b1100) : 4'b1000 >> memAddr[1:0];
    assign wlane   = MemMode == 2'b00 ? writeMemData :
                     MemMode == 2'b01 ? {2{writeMemData[15:0]}} : {4{writeMemData[7:0]}};

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        err_d      = err_q;
        mem_data_d = 32'd0;
        ram_we     = 4'h0;
        ram_addr   = ptr_q;
        ram_wdata  = load_data;
        if (state_q == LOAD) begin
            if (load_valid && ready_q) begin
                ram_we = 4'hF;
                // Pointer saturates: the transfer into the last word always ends loading.
                if (load_last || ptr_q == AW'(DEPTH_WORDS - 1))
                    state_d = RUN;
                else
                    ptr_d = ptr_q + AW'(1);
            end
        end else begin
            mem_data_d = bad ? 32'd0 : lane;
            err_d      = err_q | bad;
            ram_addr   = idx[AW-1:0];
            ram_wdata  = wlane;
            ram_we     = MemWrite && !bad ? be : 4'h0;
        end
        ready_d = state_d == LOAD;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= LOAD;
            ptr_q      <= '0;
            mem_data_q <= 32'd0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            mem_data_q <= mem_data_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we[i]) ram[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    end

    assign memData      = mem_data_q;
    assign load_ready   = ready_q;
    assign cpu_hold     = state_q == LOAD;
    assign misalign_err = err_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: directed self-checking bench for data_mem_unit
module tb_data_mem_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [1:0]  MemMode = 2'b00;
    logic [15:0] memAddr = 16'h0;
    logic [31:0] writeMemData = 32'h0;
    logic [31:0] memData;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = 32'h0;
    logic        load_last = 1'b0;
    logic        load_ready;
    logic        cpu_hold;
    logic        misalign_err;

    int n_cmp = 0;
    int n_mis = 0;
    int n_xfer = 0;

    data_mem_unit dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemMode(MemMode), .memAddr(memAddr),
        .writeMemData(writeMemData), .memData(memData), .load_valid(load_valid),
        .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
        .cpu_hold(cpu_hold), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (reset && load_valid && load_ready) n_xfer++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic acc(input logic wr, input logic [1:0] mode, input logic [15:0] addr,
                       input logic [31:0] wd);
        MemWrite = wr;
        MemMode = mode;
        memAddr = addr;
        writeMemData = wd;
        step();
    endtask

    task automatic host(input logic v, input logic [31:0] d, input logic l);
        load_valid = v;
        load_data = d;
        load_last = l;
        step();
    endtask

    initial begin
        #2 reset = 1'b0;
        step();
        chk("rst_memData", memData, 32'h0);
        chk("rst_err", {31'd0, misalign_err}, 32'd0);
        chk("rst_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        reset = 1'b1;
        step();
        chk("load_ready_up", {31'd0, load_ready}, 32'd1);
        // load with gaps; core write during LOAD must be ignored
        MemWrite = 1'b1;
        writeMemData = 32'hBAD0BAD0;
        host(1'b1, 32'h11111111, 1'b0);
        chk("hold_after_w0", {31'd0, cpu_hold}, 32'd1);
        chk("load_memData0", memData, 32'h0);
        MemWrite = 1'b0;
        host(1'b0, 32'h0, 1'b0);
        host(1'b1, 32'h22222222, 1'b0);
        host(1'b0, 32'h0, 1'b0);
        host(1'b0, 32'h0, 1'b0);
        chk("hold_after_w1", {31'd0, cpu_hold}, 32'd1);
        host(1'b1, 32'h33333333, 1'b1);
        chk("hold_fall", {31'd0, cpu_hold}, 32'd0);
        chk("ready_fall", {31'd0, load_ready}, 32'd0);
        host(1'b1, 32'hFFFFFFFF, 1'b0);
        host(1'b1, 32'hFFFFFFFF, 1'b1);
        host(1'b0, 32'h0, 1'b0);
        chk("xfer_count", n_xfer, 32'd3);
        acc(1'b0, 2'b00, 16'h0000, 32'h0);
        chk("ram0", memData, 32'h11111111);
        acc(1'b0, 2'b00, 16'h0004, 32'h0);
        chk("ram1", memData, 32'h22222222);
        acc(1'b0, 2'b00, 16'h0008, 32'h0);
        chk("ram2", memData, 32'h33333333);
        // word write then read
        acc(1'b1, 2'b00, 16'h0010, 32'hDEADBEEF);
        acc(1'b0, 2'b00, 16'h0010, 32'h0);
        chk("word_rd", memData, 32'hDEADBEEF);
        // byte write returns old byte lane at the same edge
        acc(1'b1, 2'b10, 16'h0011, 32'hFFFFFFAA);
        chk("byte_wr_old", memData, 32'h000000AD);
        acc(1'b0, 2'b01, 16'h0010, 32'h0);
        chk("half_hi", memData, 32'h0000DEAA);
        acc(1'b0, 2'b01, 16'h0012, 32'h0);
        chk("half_lo", memData, 32'h0000BEEF);
        acc(1'b0, 2'b10, 16'h0013, 32'h0);
        chk("byte3", memData, 32'h000000EF);
        acc(1'b0, 2'b10, 16'h0010, 32'h0);
        chk("byte0", memData, 32'h000000DE);
        acc(1'b0, 2'b00, 16'h0010, 32'h0);
        chk("word_merged", memData, 32'hDEAABEEF);
        // half write into low half
        acc(1'b1, 2'b01, 16'h000A, 32'hFFFF1234);
        acc(1'b0, 2'b00, 16'h0008, 32'h0);
        chk("half_wr", memData, 32'h33331234);
        chk("no_err_yet", {31'd0, misalign_err}, 32'd0);
        // read-before-write
        acc(1'b1, 2'b00, 16'h0020, 32'h00000001);
        acc(1'b1, 2'b00, 16'h0020, 32'h00000002);
        chk("rbw_old", memData, 32'h00000001);
        acc(1'b0, 2'b00, 16'h0020, 32'h0);
        chk("rbw_new", memData, 32'h00000002);
        // misaligned word write
        acc(1'b1, 2'b00, 16'h0012, 32'h12345678);
        chk("mis_memData", memData, 32'h0);
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        acc(1'b0, 2'b00, 16'h0010, 32'h0);
        chk("mis_ram_keep", memData, 32'hDEAABEEF);
        chk("mis_sticky", {31'd0, misalign_err}, 32'd1);
        acc(1'b0, 2'b01, 16'h0011, 32'h0);
        chk("mis_half", memData, 32'h0);
        acc(1'b0, 2'b11, 16'h0010, 32'h0);
        chk("mis_mode11", memData, 32'h0);
        // out of range: index 1024 must not alias word 0
        acc(1'b1, 2'b00, 16'h1000, 32'hCAFEF00D);
        chk("oob_wr_rd", memData, 32'h0);
        acc(1'b0, 2'b00, 16'h1000, 32'h0);
        chk("oob_rd", memData, 32'h0);
        acc(1'b0, 2'b00, 16'h0000, 32'h0);
        chk("oob_no_alias", memData, 32'h11111111);
        acc(1'b0, 2'b00, 16'h0FFC, 32'h0);
        chk("last_ok_err", {31'd0, misalign_err}, 32'd1);
        // reset mid-load
        reset = 1'b0;
        #1;
        chk("rst2_err", {31'd0, misalign_err}, 32'd0);
        chk("rst2_memData", memData, 32'h0);
        chk("rst2_hold", {31'd0, cpu_hold}, 32'd1);
        step();
        reset = 1'b1;
        step();
        chk("rst2_ready", {31'd0, load_ready}, 32'd1);
        host(1'b1, 32'hA0A0A0A0, 1'b0);
        host(1'b1, 32'hB1B1B1B1, 1'b0);
        chk("mid_err", {31'd0, misalign_err}, 32'd0);
        load_data = 32'hEEEEEEEE;
        reset = 1'b0;
        step();
        chk("mid_rst_err", {31'd0, misalign_err}, 32'd0);
        reset = 1'b1;
        load_valid = 1'b0;
        step();
        chk("rst3_ready", {31'd0, load_ready}, 32'd1);
        host(1'b1, 32'hC2C2C2C2, 1'b1);
        chk("reload_hold", {31'd0, cpu_hold}, 32'd0);
        host(1'b0, 32'h0, 1'b0);
        acc(1'b0, 2'b00, 16'h0000, 32'h0);
        chk("reload_ram0", memData, 32'hC2C2C2C2);
        acc(1'b0, 2'b00, 16'h0004, 32'h0);
        chk("reload_ram1", memData, 32'hB1B1B1B1);
        acc(1'b0, 2'b00, 16'h0008, 32'h0);
        chk("reload_ram2", memData, 32'h33331234);
        chk("reload_err", {31'd0, misalign_err}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
